// File: rtl/mux_scan_pkg.sv
// Shared types and default parameters for the mux channel scan sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CONV   = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_DATA_W      = 12;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/mux_scan_next.sv
// Finds the lowest enabled channel index at or above 'from'; 'found' is low when none exists.
module mux_scan_next
  import mux_scan_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 6
) (
  input  logic [N-1:0] en,
  input  logic [W:0]   from,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] cand;

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = en[gi] && ((W+1)'(gi) >= from);
  end

  // Descending scan so the lowest candidate is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Channel scan sequencer: steps the decoder address, settles, converts, publishes tagged samples.
// Optional SCAN_SKIP_EN adds a chan_en mask so only enabled channels are scanned.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LAST_ADDR   = 31,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SCAN_SKIP_EN
  input  logic [LAST_ADDR:0] chan_en,
`endif
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              sample_vld,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [DATA_W-1:0] sample_data,
  output logic              frame_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LOAD  = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LOAD = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST         = ADDR_W'(LAST_ADDR);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [SCNT_W-1:0]   scnt_reg, scnt_next;
  logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;
  logic                adc_start_reg, adc_start_next;
  logic                sample_vld_reg, sample_vld_next;
  logic [ADDR_W-1:0]   sample_addr_reg, sample_addr_next;
  logic [DATA_W-1:0]   sample_data_reg, sample_data_next;
  logic                frame_done_reg, frame_done_next;
  logic                busy_reg, busy_next;
  logic                err_reg, err_next;
  logic                advance;

  logic [ADDR_W-1:0]   first_addr, next_addr;
  logic                has_first, has_next;

`ifdef SCAN_SKIP_EN
  logic [ADDR_W:0] next_from;
  assign next_from = {1'b0, addr_reg} + (ADDR_W+1)'(1);

  mux_scan_next #(.N(LAST_ADDR + 1), .W(ADDR_W)) u_first (
    .en   (chan_en),
    .from ('0),
    .idx  (first_addr),
    .found(has_first)
  );

  mux_scan_next #(.N(LAST_ADDR + 1), .W(ADDR_W)) u_next (
    .en   (chan_en),
    .from (next_from),
    .idx  (next_addr),
    .found(has_next)
  );
`else
  assign first_addr = '0;
  assign has_first  = 1'b1;
  assign next_addr  = addr_reg + ADDR_W'(1);
  assign has_next   = (addr_reg != LAST);
`endif

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    scnt_next        = scnt_reg;
    tcnt_next        = tcnt_reg;
    adc_start_next   = 1'b0;
    sample_vld_next  = 1'b0;
    sample_addr_next = sample_addr_reg;
    sample_data_next = sample_data_reg;
    frame_done_next  = 1'b0;
    err_next         = err_reg;
    advance          = 1'b0;

    if (abort) begin
      state_next = IDLE;
      addr_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && has_first) begin
            state_next = SETTLE;
            addr_next  = first_addr;
            scnt_next  = SETTLE_LOAD;
            err_next   = 1'b0;
          end
        end
        SETTLE: begin
          if (scnt_reg == '0) begin
            state_next     = CONV;
            adc_start_next = 1'b1;
          end else begin
            scnt_next = scnt_reg - SCNT_W'(1);
          end
        end
        CONV: begin
          state_next = WAIT;
          tcnt_next  = TIMEOUT_LOAD;
        end
        WAIT: begin
          // A done arriving on the expiry cycle still counts as a good conversion.
          if (adc_done) begin
            sample_vld_next  = 1'b1;
            sample_addr_next = addr_reg;
            sample_data_next = adc_data;
            advance          = 1'b1;
          end else if (tcnt_reg == '0) begin
            err_next = 1'b1;
            advance  = 1'b1;
          end else begin
            tcnt_next = tcnt_reg - TCNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase

      if (advance) begin
        if (has_next) begin
          addr_next  = next_addr;
          state_next = SETTLE;
          scnt_next  = SETTLE_LOAD;
        end else begin
          frame_done_next = 1'b1;
          if (cont && has_first) begin
            addr_next  = first_addr;
            state_next = SETTLE;
            scnt_next  = SETTLE_LOAD;
          end else begin
            addr_next  = '0;
            state_next = IDLE;
          end
        end
      end
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      scnt_reg        <= '0;
      tcnt_reg        <= '0;
      adc_start_reg   <= 1'b0;
      sample_vld_reg  <= 1'b0;
      sample_addr_reg <= '0;
      sample_data_reg <= '0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      scnt_reg        <= scnt_next;
      tcnt_reg        <= tcnt_next;
      adc_start_reg   <= adc_start_next;
      sample_vld_reg  <= sample_vld_next;
      sample_addr_reg <= sample_addr_next;
      sample_data_reg <= sample_data_next;
      frame_done_reg  <= frame_done_next;
      busy_reg        <= busy_next;
      err_reg         <= err_next;
    end
  end

  assign addr        = addr_reg;
  assign adc_start   = adc_start_reg;
  assign sample_vld  = sample_vld_reg;
  assign sample_addr = sample_addr_reg;
  assign sample_data = sample_data_reg;
  assign frame_done  = frame_done_reg;
  assign busy        = busy_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: timeline-based reference model, directed scenarios, then random traffic.
module tb_mux_scan_seq;

  localparam int AW   = 6;
  localparam int DW   = 12;
  localparam int LAST = 3;
  localparam int S    = 4;
  localparam int T    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic          adc_done = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [LAST:0] en_mask = '1;
  logic [AW-1:0] addr, sample_addr;
  logic [DW-1:0] sample_data;
  logic          adc_start, sample_vld, frame_done, busy, err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fixed_lat = 3;
  int withhold = -1;
  logic stray_en = 1'b0;

  mux_scan_seq #(
    .ADDR_W(AW), .LAST_ADDR(LAST), .SETTLE_CYC(S), .TIMEOUT_CYC(T), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SCAN_SKIP_EN
    .chan_en(en_mask),
`endif
    .start(start),
    .cont(cont),
    .abort(abort),
    .addr(addr),
    .adc_start(adc_start),
    .adc_done(adc_done),
    .adc_data(adc_data),
    .sample_vld(sample_vld),
    .sample_addr(sample_addr),
    .sample_data(sample_data),
    .frame_done(frame_done),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each channel is a timeline anchored at the edge its address was set.
  typedef struct {
    logic          busy;
    logic [AW-1:0] addr;
    int            t0;
    logic          err;
    logic          adc_st;
    logic          sv;
    logic          fd;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
  } mstate_t;

  mstate_t m;

  function automatic int first_en(input logic [LAST:0] en);
    for (int i = 0; i <= LAST; i++) if (en[i]) return i;
    return -1;
  endfunction

  function automatic int next_en(input logic [LAST:0] en, input int cur);
    for (int i = cur + 1; i <= LAST; i++) if (en[i]) return i;
    return -1;
  endfunction

  function automatic mstate_t m_reset();
    mstate_t r;
    r.busy = 0; r.addr = '0; r.t0 = 0; r.err = 0; r.adc_st = 0;
    r.sv = 0; r.fd = 0; r.sa = '0; r.sd = '0;
    return r;
  endfunction

  function automatic mstate_t m_step(input mstate_t mi, input logic st, input logic ab,
                                     input logic ct, input logic dn, input logic [DW-1:0] dat,
                                     input logic [LAST:0] en, input int now);
    mstate_t r;
    int rel, nx, f;
    logic acc, tmo;
    r = mi;
    r.sv = 0;
    r.fd = 0;
    if (ab) begin
      r.busy = 0;
      r.addr = '0;
    end else if (!r.busy) begin
      f = first_en(en);
      if (st && f >= 0) begin
        r.busy = 1; r.addr = AW'(f); r.t0 = now; r.err = 0;
      end
    end else begin
      rel = now - r.t0;
      acc = dn && rel >= S + 2 && rel <= S + 1 + T;
      tmo = !acc && rel == S + 1 + T;
      if (acc) begin
        r.sv = 1; r.sa = r.addr; r.sd = dat;
      end
      if (tmo) r.err = 1;
      if (acc || tmo) begin
        nx = next_en(en, int'(r.addr));
        if (nx >= 0) begin
          r.addr = AW'(nx); r.t0 = now;
        end else begin
          r.fd = 1;
          f = first_en(en);
          if (ct && f >= 0) begin
            r.addr = AW'(f); r.t0 = now;
          end else begin
            r.busy = 0; r.addr = '0;
          end
        end
      end
    end
    r.adc_st = r.busy && (now - r.t0 == S);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else        m <= m_step(m, start, abort, cont, adc_done, adc_data, en_mask, cyc);
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("addr", 32'(addr), 32'(m.addr));
      chk("adc_start", 32'(adc_start), 32'(m.adc_st));
      chk("sample_vld", 32'(sample_vld), 32'(m.sv));
      chk("sample_addr", 32'(sample_addr), 32'(m.sa));
      chk("sample_data", 32'(sample_data), 32'(m.sd));
      chk("frame_done", 32'(frame_done), 32'(m.fd));
      chk("busy", 32'(busy), 32'(m.busy));
      chk("err_timeout", 32'(err_timeout), 32'(m.err));
      if (sample_vld)
        $display("sample ch=%0d data=%03h frame_done=%0b cycle=%0d", sample_addr, sample_data, frame_done, cyc);
    end
  end

  // ADC responder: done after a chosen latency from the adc_start cycle (0 = withheld).
  initial begin
    int pend;
    pend = 0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_done = 1'b1;
          adc_data = DW'($urandom);
        end
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        adc_done = 1'b1;
        adc_data = DW'($urandom);
      end
      if (adc_start) begin
        if (withhold >= 0 && int'(addr) == withhold) pend = 0;
        else if (fixed_lat > 0) pend = fixed_lat;
        else pend = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T + 2));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int k0, nsv, first_as, fd_rel, nfd, fd1, as_after, n;
    int sv_rel[4];
    int sv_addr[4];

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err_timeout), 32'd0);

    // Single-shot frame, latency 3: channel period 8, first adc_start 4 after start.
    fixed_lat = 3;
    pulse_start();
    k0 = cyc;
    nsv = 0; first_as = -1; fd_rel = -1;
    for (int i = 0; i < 4; i++) begin sv_rel[i] = -1; sv_addr[i] = -1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (adc_start && first_as < 0) first_as = cyc - k0;
      if (sample_vld) begin
        if (nsv < 4) begin sv_rel[nsv] = cyc - k0; sv_addr[nsv] = int'(sample_addr); end
        nsv++;
      end
      if (frame_done) fd_rel = cyc - k0;
    end
    chk("dir_first_adc_start", 32'(first_as), 32'd4);
    chk("dir_nsamples", 32'(nsv), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("dir_sample_time", 32'(sv_rel[i]), 32'(8 * (i + 1)));
      chk("dir_sample_addr", 32'(sv_addr[i]), 32'(i));
    end
    chk("dir_frame_done_time", 32'(fd_rel), 32'd32);
    chk("dir_end_addr", 32'(addr), 32'd0);
    chk("dir_end_busy", 32'(busy), 32'd0);

    // Continuous: two frames back to back, cont dropped during the second.
    fixed_lat = 2;
    cont = 1'b1;
    pulse_start();
    nfd = 0; fd1 = -1; as_after = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (adc_start && fd1 >= 0 && as_after < 0) as_after = cyc - fd1;
      if (frame_done) begin
        nfd++;
        if (nfd == 1) begin
          fd1 = cyc;
          cont = 1'b0;
          chk("cont_wrap_addr", 32'(addr), 32'd0);
          chk("cont_wrap_busy", 32'(busy), 32'd1);
        end
      end
      if (!busy) break;
    end
    chk("cont_frames", 32'(nfd), 32'd2);
    chk("cont_restart_settle", 32'(as_after), 32'(S));
    wait_idle("cont_idle");

    // Timeout on channel 2.
    withhold = 2;
    pulse_start();
    n = 0;
    for (int i = 0; i < 4; i++) sv_addr[i] = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_vld) begin
        if (n < 4) sv_addr[n] = int'(sample_addr);
        n++;
      end
      if (!busy) break;
    end
    chk("to_nsamples", 32'(n), 32'd3);
    chk("to_addr0", 32'(sv_addr[0]), 32'd0);
    chk("to_addr1", 32'(sv_addr[1]), 32'd1);
    chk("to_addr2", 32'(sv_addr[2]), 32'd3);
    chk("to_err_set", 32'(err_timeout), 32'd1);
    withhold = -1;
    pulse_start();
    chk("to_err_cleared", 32'(err_timeout), 32'd0);
    chk("to_restart_busy", 32'(busy), 32'd1);
    wait_idle("to_idle");

    // Abort in WAIT coinciding with adc_done; a mid-frame start is ignored.
    fixed_lat = 3;
    pulse_start();
    @(negedge clk);
    pulse_start();
    chk("ab_start_ignored_addr", 32'(addr), 32'd0);
    chk("ab_start_ignored_busy", 32'(busy), 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (adc_start && addr == AW'(1)) begin n = 1; break; end
    end
    chk("ab_reached_ch1", 32'(n), 32'd1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("ab_done_coincident", 32'(adc_done), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_no_sample", 32'(sample_vld), 32'd0);
    chk("ab_idle", 32'(busy), 32'd0);
    chk("ab_addr", 32'(addr), 32'd0);

    // Asynchronous reset in the middle of SETTLE.
    pulse_start();
    @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_sample_vld", 32'(sample_vld), 32'd0);
    chk("rst_sample_addr", 32'(sample_addr), 32'd0);
    chk("rst_sample_data", 32'(sample_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_stays_idle", 32'(busy), 32'd0);

`ifdef SCAN_SKIP_EN
    fixed_lat = 2;
    en_mask = 4'b1010;
    pulse_start();
    n = 0;
    for (int i = 0; i < 4; i++) sv_addr[i] = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_vld) begin
        if (n < 4) sv_addr[n] = int'(sample_addr);
        n++;
      end
      if (!busy) break;
    end
    chk("skip_nsamples", 32'(n), 32'd2);
    chk("skip_addr0", 32'(sv_addr[0]), 32'd1);
    chk("skip_addr1", 32'(sv_addr[1]), 32'd3);
    en_mask = '0;
    pulse_start();
    chk("skip_empty_start", 32'(busy), 32'd0);
    en_mask = '1;
`endif

    // Random traffic: stray dones, random latencies, starts, aborts, cont toggling.
    fixed_lat = 0;
    stray_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 39) == 0) cont = ~cont;
`ifdef SCAN_SKIP_EN
      if ($urandom_range(0, 19) == 0) en_mask = (LAST + 1)'($urandom);
`endif
    end
    start = 1'b0;
    cont = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    stray_en = 1'b0;
    @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Channel scan sequencer that sits directly upstream of the analog mux address decoder (`switch`) and drives its `addr` input. It steps the 6-bit channel address through a frame of 0..LAST_ADDR. After each step it waits a programmable settle time, triggers one ADC conversion, and publishes the result tagged with its channel. It runs single-shot or continuous, with abort and conversion-timeout handling.

## Interface
Parameters:
- `ADDR_W`, default 6. Width of the channel address; matches the decoder `addr` input.
- `LAST_ADDR`, default 31. Highest channel in a frame; must be less than 2^ADDR_W.
- `SETTLE_CYC`, default 16. Cycles from an address change to `adc_start`. Minimum 2, which covers the decoder's one-cycle register.
- `TIMEOUT_CYC`, default 1024. Maximum cycles to wait for `adc_done`.
- `DATA_W`, default 12. ADC sample width.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: starts a frame when the block is IDLE.
- `cont` in 1: level, sampled at frame end. 1 = start the next frame immediately.
- `abort` in 1: returns the block to IDLE from any state.
- `addr` out ADDR_W: channel address to the decoder.
- `adc_start` out 1: one-cycle conversion request.
- `adc_done` in 1: one-cycle conversion-complete strobe.
- `adc_data` in DATA_W: valid when `adc_done`=1.
- `sample_vld` out 1: one-cycle strobe; the sample outputs below are valid.
- `sample_addr` out ADDR_W: channel of the sample.
- `sample_data` out DATA_W: captured ADC value.
- `frame_done` out 1: one-cycle strobe on completion of the last channel.
- `busy` out 1: high whenever the state is not IDLE.
- `err_timeout` out 1: sticky; at least one conversion timed out.

## Operation
- FSM states: IDLE, SETTLE, CONV, WAIT.
- IDLE:
  - `addr`=0 and `busy`=0.
  - `start`=1 → SETTLE. On the same edge: `addr`←first channel, settle counter←SETTLE_CYC-1, `err_timeout`←0.
- SETTLE: counts down. At count 0 → CONV, with `adc_start`←1.
- CONV:
  - `adc_start` is high for exactly this one cycle.
  - Next state is WAIT. Timeout counter←TIMEOUT_CYC-1.
- WAIT, on `adc_done`=1:
  - Capture `adc_data` into `sample_data` and `addr` into `sample_addr`.
  - Pulse `sample_vld`.
  - Then advance (see below).
- WAIT, when the timeout counter reaches 0 without `adc_done`:
  - Set `err_timeout`; no `sample_vld`.
  - Then advance.
- Advance:
  - If `addr`≠LAST_ADDR: `addr`←next channel, → SETTLE with the counter reloaded.
  - If `addr`=LAST_ADDR: pulse `frame_done`. With `cont`=1, `addr`←first channel and → SETTLE; otherwise `addr`←0 and → IDLE.
- Precedence and ignored inputs:
  - `abort` has priority over everything, including a same-cycle `start` or `adc_done`.
  - On `abort`: → IDLE next edge, `addr`←0, no `sample_vld` or `frame_done`. `err_timeout` is kept.
  - `start` while busy: ignored.
  - `adc_done` outside WAIT: ignored.
  - `adc_done` in the same cycle as timeout expiry: treated as done, and `err_timeout` is not set.
- Reset values:
  - State IDLE.
  - All outputs 0: `addr`, `adc_start`, `sample_vld`, `sample_addr`, `sample_data`, `frame_done`, `busy`, `err_timeout`.
  - Asserting reset mid-frame forces these values immediately (asynchronous).
- Counters are unsigned, sized $clog2 of their parameter, and never wrap.

## Timing
- All outputs are registered.
- Per-channel flow:
  - `start` sampled at edge k → `addr` valid from edge k.
  - `adc_start` high from edge k+SETTLE_CYC for one cycle.
  - `adc_done` sampled at edge m → `sample_vld`, `sample_*` and the new `addr` all update at edge m.
  - The next `adc_start` is at m+SETTLE_CYC.
- Channel period = SETTLE_CYC + 1 + ADC latency. ADC latency is counted from the `adc_start` cycle to the `adc_done` cycle.
- `frame_done` is coincident with the last `sample_vld`.
- Continuous mode has no idle gap between frames.

## Configuration
- `SCAN_SKIP_EN` defined:
  - Adds input `chan_en` [LAST_ADDR:0].
  - "First channel" is the lowest enabled index. "Next channel" is the lowest enabled index above the current one.
  - A frame ends when no enabled index lies above the current one.
  - `start` with `chan_en`=0 is ignored, and the block stays in IDLE.
  - `chan_en` is sampled at `start` and at each advance.
- `SCAN_SKIP_EN` undefined: the port is absent, and every channel 0..LAST_ADDR is scanned in order.

## Structure
- Package `mux_scan_pkg`: state enum, default ADDR_W and DATA_W, SETTLE_CYC and TIMEOUT_CYC defaults.
- One sub-module, `mux_scan_next`: combinational next-enabled-channel finder (priority encoder with found flag). It is instantiated only under `SCAN_SKIP_EN`.

## Test plan
- Single-shot frame, SETTLE_CYC=4, LAST_ADDR=3, ADC done 3 cycles after `adc_start`:
  - 4 `sample_vld` with `sample_addr` 0,1,2,3 and `sample_data` matching the ADC values.
  - `frame_done` coincident with the addr-3 sample.
  - `addr`=0 and `busy`=0 afterwards.
- Continuous, `cont`=1 for two frames:
  - `addr` goes from 3 back to 0 and SETTLE restarts with no IDLE cycle.
  - `frame_done` pulses twice.
- Timeout: `adc_done` withheld on addr 2, TIMEOUT_CYC=8:
  - `err_timeout`=1; no sample for addr 2; scan continues to addr 3.
  - The next `start` clears `err_timeout`.
- `abort` during WAIT with `adc_done` in the same cycle:
  - No `sample_vld`; IDLE next cycle; `addr`=0.
  - A `start` during the frame was ignored.
- `rst_n` low mid-SETTLE: all outputs 0 immediately; after release the block stays in IDLE until `start`.
- With `SCAN_SKIP_EN`:
  - `chan_en`=4'b1010 → samples only for addr 1 and 3.
  - `chan_en`=0 → `start` ignored.
